// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic tile.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } tile_state_t;

    // Bits needed by the drain counter, which counts up to 2N-1.
    function automatic int drain_cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_array_tile_pe.sv
// One MAC cell: forwards a east and b south with their valid bits, accumulates a*b.
module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  acc_rd
);

    logic [DATA_W-1:0]         a_r;
    logic [DATA_W-1:0]         b_r;
    logic                      a_vld_r;
    logic                      b_vld_r;
    logic [ACC_W-1:0]          acc_r;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s;

    assign prod_s     = (2*DATA_W)'($signed(a_in)) * (2*DATA_W)'($signed(b_in));
    assign prod_ext_s = ACC_W'(prod_s);

    // Operand pass-through registers and the wrapping accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r     <= '0;
            b_r     <= '0;
            a_vld_r <= 1'b0;
            b_vld_r <= 1'b0;
            acc_r   <= '0;
        end else begin
            a_r     <= a_in;
            b_r     <= b_in;
            a_vld_r <= a_vld_in;
            b_vld_r <= b_vld_in;
            if (clear) begin
                acc_r <= '0;
            end else if (a_vld_in && b_vld_in) begin
                acc_r <= acc_r + prod_ext_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign a_out     = a_r;
    assign b_out     = b_r;
    assign a_vld_out = a_vld_r;
    assign b_vld_out = b_vld_r;
    assign acc_rd    = acc_r;

endmodule

// File: rtl/systolic_array_tile.sv
// NxN output-stationary matrix-multiply tile: skewed operand injection, PE grid, row-wise result readout.
module systolic_array_tile
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic [N*DATA_W-1:0]   in_b,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_row,
    output logic [N*ACC_W-1:0]    out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W = $clog2(N);
    localparam int CNT_W = drain_cnt_w(N);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N - 1);

    tile_state_t        state_r;
    tile_state_t        state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               out_valid_r;
    logic [ROW_W-1:0]   out_row_r;
    logic [N*ACC_W-1:0] out_data_r;
    logic               accept_s;
    logic               out_hs_s;
    logic               clear_s;
    logic [ROW_W-1:0]   row_sel_s;
    logic [N*ACC_W-1:0] row_data_s;

    logic [DATA_W-1:0] a_h_s  [N][N+1];
    logic              av_h_s [N][N+1];
    logic [DATA_W-1:0] b_v_s  [N+1][N];
    logic              bv_v_s [N+1][N];
    logic [ACC_W-1:0]  acc_s  [N][N];

    assign accept_s = in_valid & in_ready_r;
    assign out_hs_s = out_valid_r & out_ready;
    assign clear_s  = out_hs_s && (out_row_r == ROW_LAST);

    for (genvar gi = 0; gi < N; gi++) begin : g_a_skew
        logic [DATA_W-1:0] dly_r [gi+1];
        logic [gi:0]       vld_r;
        // Row gi of A is delayed gi+1 edges before entering column 0.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= gi; s++) dly_r[s] <= '0;
                vld_r <= '0;
            end else begin
                dly_r[0] <= accept_s ? in_a[gi*DATA_W +: DATA_W] : '0;
                vld_r[0] <= accept_s;
                for (int s = 1; s <= gi; s++) begin
                    dly_r[s] <= dly_r[s-1];
                    vld_r[s] <= vld_r[s-1];
                end
            end
        end
        assign a_h_s[gi][0]  = dly_r[gi];
        assign av_h_s[gi][0] = vld_r[gi];
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_b_skew
        logic [DATA_W-1:0] dly_r [gj+1];
        logic [gj:0]       vld_r;
        // Column gj of B is delayed gj+1 edges before entering row 0.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= gj; s++) dly_r[s] <= '0;
                vld_r <= '0;
            end else begin
                dly_r[0] <= accept_s ? in_b[gj*DATA_W +: DATA_W] : '0;
                vld_r[0] <= accept_s;
                for (int s = 1; s <= gj; s++) begin
                    dly_r[s] <= dly_r[s-1];
                    vld_r[s] <= vld_r[s-1];
                end
            end
        end
        assign b_v_s[0][gj]  = dly_r[gj];
        assign bv_v_s[0][gj] = vld_r[gj];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk       (clk),
                .rst       (rst),
                .clear     (clear_s),
                .a_in      (a_h_s[gi][gj]),
                .a_vld_in  (av_h_s[gi][gj]),
                .b_in      (b_v_s[gi][gj]),
                .b_vld_in  (bv_v_s[gi][gj]),
                .a_out     (a_h_s[gi][gj+1]),
                .a_vld_out (av_h_s[gi][gj+1]),
                .b_out     (b_v_s[gi+1][gj]),
                .b_vld_out (bv_v_s[gi+1][gj]),
                .acc_rd    (acc_s[gi][gj])
            );
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = in_last ? DRAIN : STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (accept_s && in_last) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_next_s = OUTPUT;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            OUTPUT: begin
                if (clear_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUTPUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Row to load into the output register on the coming edge.
    always_comb begin
        row_sel_s  = '0;
        row_data_s = '0;
        if (state_r == DRAIN || out_row_r == ROW_LAST) begin
            row_sel_s = '0;
        end else begin
            row_sel_s = out_row_r + ROW_W'(1);
        end
        for (int j = 0; j < N; j++) begin
            row_data_s[j*ACC_W +: ACC_W] = acc_s[row_sel_s][j];
        end
    end

    // State, drain counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= (state_r == DRAIN) ? cnt_r + CNT_W'(1) : '0;
            in_ready_r <= (state_next_s == IDLE) || (state_next_s == STREAM);
            busy_r     <= (state_next_s != IDLE);
            done_r     <= clear_s;
        end
    end

    // Result row register: loaded at end of drain, advanced on each handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_row_r   <= '0;
            out_data_r  <= '0;
        end else if (state_r == DRAIN && state_next_s == OUTPUT) begin
            out_valid_r <= 1'b1;
            out_row_r   <= '0;
            out_data_r  <= row_data_s;
        end else if (clear_s) begin
            out_valid_r <= 1'b0;
            out_row_r   <= '0;
            out_data_r  <= '0;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b1;
            out_row_r   <= row_sel_s;
            out_data_r  <= row_data_s;
        end else begin
            out_valid_r <= out_valid_r;
            out_row_r   <= out_row_r;
            out_data_r  <= out_data_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_systolic_array_tile.sv
// Randomized self-checking bench for systolic_array_tile against a plain matrix-product model.
module tb_systolic_array_tile;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DATA_W-1:0]  in_a;
    logic [N*DATA_W-1:0]  in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_row;
    logic [N*ACC_W-1:0]   out_data;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [DATA_W-1:0] a_m [N][16];
    logic signed [DATA_W-1:0] b_m [16][N];
    logic [ACC_W-1:0]         c_exp [N][N];

    systolic_array_tile #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_busy"},      64'(busy),      64'd0);
        check_eq({tag, "_done"},      64'(done),      64'd0);
        check_eq({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check_eq({tag, "_out_row"},   64'(out_row),   64'd0);
        for (int j = 0; j < N; j++)
            check_eq({tag, "_out_data"}, 64'(out_data[j*ACC_W +: ACC_W]), 64'd0);
    endtask

    // C = A*B with the product widened and the sum wrapped to ACC_W bits.
    task automatic compute_model(input int k_len);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int k = 0; k < k_len; k++)
                    s += longint'(a_m[i][k]) * longint'(b_m[k][j]);
                c_exp[i][j] = s[ACC_W-1:0];
            end
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                a_m[i][k] = (i == k) ? 16'sd1 : 16'sd0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                b_m[k][j] = 16'(N * k + j + 1);
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            in_a[i*DATA_W +: DATA_W] = a_m[i][k];
            in_b[i*DATA_W +: DATA_W] = b_m[k][i];
        end
    endtask

    // gap < 0: random bubbles; stall_len < 0: random backpressure on every row.
    task automatic run_tile(input int k_len, input int gap, input int stall_row, input int stall_len);
        int t_last;
        int n;
        int stalls;
        compute_model(k_len);
        for (int k = 0; k < k_len; k++) begin
            n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (k == 0 && gap >= 0) n = 0;
            for (int g = 0; g < n; g++) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                in_a     = {$urandom, $urandom};
                @(negedge clk);
                if (k > 0) check_eq("busy_bubble", 64'(busy), 64'd1);
            end
            in_valid = 1'b1;
            in_last  = (k == k_len - 1);
            drive_beat(k);
            check_eq("in_ready_beat", 64'(in_ready), 64'd1);
            @(negedge clk);
        end
        t_last   = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("in_ready_drain", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 64) begin
            in_valid = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("out_valid_rise", 64'(out_valid), 64'd1);
        check_eq("latency", 64'(cyc - t_last), 64'(2 * N));
        for (int r = 0; r < N; r++) begin
            if (r == stall_row) stalls = stall_len;
            else if (stall_len < 0) stalls = int'($urandom_range(0, 2));
            else stalls = 0;
            for (int s = 0; s <= stalls; s++) begin
                check_eq("row_valid", 64'(out_valid), 64'd1);
                check_eq("row_index", 64'(out_row), 64'(r));
                for (int j = 0; j < N; j++)
                    check_eq("row_data", 64'(out_data[j*ACC_W +: ACC_W]), 64'(c_exp[r][j]));
                if (s < stalls) check_eq("in_ready_hold", 64'(in_ready), 64'd0);
                out_ready = (s == stalls);
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("post_out_valid", 64'(out_valid), 64'd0);
        check_eq("post_busy", 64'(busy), 64'd0);
        check_eq("post_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check_eq("done_clear", 64'(done), 64'd0);
    endtask

    task automatic fill_const(input logic [DATA_W-1:0] v);
        a_m[0][0] = v; a_m[1][0] = v; a_m[2][0] = v; a_m[3][0] = v;
        for (int j = 0; j < N; j++) b_m[0][j] = v;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_reset("rst_init");
        rst = 1'b1;
        @(negedge clk);

        set_identity();
        run_tile(4, 0, -1, 0);

        set_identity();
        run_tile(4, 2, -1, 0);

        set_identity();
        run_tile(4, 0, 2, 3);

        fill_const(16'hFFFF);
        run_tile(1, 0, -1, 0);
        fill_const(16'h8000);
        run_tile(1, 0, -1, 0);
        for (int j = 0; j < N; j++)
            check_eq("model_8000", 64'(c_exp[0][j]), 64'h0040000000);

        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) begin
                a_m[i][k] = 16'($urandom);
                b_m[k][i] = 16'($urandom);
            end
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_last  = 1'b0;
            drive_beat(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle_reset("rst_abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        set_identity();
        run_tile(4, 0, -1, 0);

        for (int t = 0; t < 6; t++) begin
            int k_len;
            k_len = int'($urandom_range(1, 8));
            for (int k = 0; k < k_len; k++)
                for (int i = 0; i < N; i++) begin
                    a_m[i][k] = 16'($urandom);
                    b_m[k][i] = 16'($urandom);
                end
            run_tile(k_len, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
